// File: rtl/vga_draw_arbiter.sv
// Four-way draw-port arbiter in front of a VGA pixel writer: one sprite engine owns the port at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module vga_draw_arbiter #(
    parameter logic [7:0]  X_SCREEN_PIXELS = 8'd160,
    parameter logic [6:0]  Y_SCREEN_PIXELS = 7'd120,
    parameter logic [15:0] MAX_HOLD        = 16'd2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  done,
    input  logic [3:0]  plot_in,
    input  logic [31:0] x_in,
    input  logic [27:0] y_in,
    input  logic [11:0] colour_in,
    output logic [3:0]  grant,
    output logic [7:0]  xout,
    output logic [6:0]  yout,
    output logic [2:0]  colourOut,
    output logic        drawEn,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  winner_q, winner_d;
    logic [3:0]  grant_q, grant_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  xout_q, xout_d;
    logic [6:0]  yout_q, yout_d;
    logic [2:0]  colour_q, colour_d;
    logic        drawen_q, drawen_d;

    logic [1:0]  pick;
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;
    logic [2:0]  cur_colour;
    logic        cur_plot, cur_done, cur_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;
    logic [1:0] rr_idx;

    // Walk downward so the nearest index after last_q is assigned last and wins.
    always_comb begin
        pick   = last_q;
        rr_idx = last_q;
        for (int k = 4; k >= 1; k--) begin
            rr_idx = last_q + k[1:0];
            if (req[rr_idx]) begin
                pick = rr_idx;
            end
        end
    end
`else
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                pick = i[1:0];
            end
        end
    end
`endif

    // Slice out the current owner's pixel and handshake bits.
    always_comb begin
        cur_x      = '0;
        cur_y      = '0;
        cur_colour = '0;
        cur_plot   = 1'b0;
        cur_done   = 1'b0;
        cur_req    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (winner_q == i[1:0]) begin
                cur_x      = x_in[8*i +: 8];
                cur_y      = y_in[7*i +: 7];
                cur_colour = colour_in[3*i +: 3];
                cur_plot   = plot_in[i];
                cur_done   = done[i];
                cur_req    = req[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        grant_d  = grant_q;
        hold_d   = hold_q;
        xout_d   = xout_q;
        yout_d   = yout_q;
        colour_d = colour_q;
        drawen_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (|req) begin
                    winner_d = pick;
                    grant_d  = 4'b0001 << pick;
                    hold_d   = '0;
                    state_d  = S_GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d   = pick;
`endif
                end
            end
            S_GRANT: begin
                // The pixel of the exit cycle is still forwarded.
                xout_d   = cur_x;
                yout_d   = cur_y;
                colour_d = cur_colour;
                drawen_d = cur_plot && (cur_x < X_SCREEN_PIXELS) && (cur_y < Y_SCREEN_PIXELS);
                hold_d   = hold_q + 16'd1;
                if (cur_done || !cur_req || (hold_q == MAX_HOLD - 16'd1)) begin
                    grant_d = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            winner_q <= '0;
            grant_q  <= '0;
            hold_q   <= '0;
            xout_q   <= '0;
            yout_q   <= '0;
            colour_q <= '0;
            drawen_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= 2'd3;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            grant_q  <= grant_d;
            hold_q   <= hold_d;
            xout_q   <= xout_d;
            yout_q   <= yout_d;
            colour_q <= colour_d;
            drawen_q <= drawen_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign xout      = xout_q;
    assign yout      = yout_q;
    assign colourOut = colour_q;
    assign drawEn    = drawen_q;
    assign busy      = (state_q == S_GRANT);

endmodule
